// File: rtl/conv_skew_feeder.sv
// conv_skew_feeder
//
// Sits between the data mover's memory read ports and a PE_SIZE x PE_SIZE
// systolic array. Activation words are split into byte lanes and delayed
// diagonally (lane i is delayed by i+1 cycles past the read data), so the
// array sees the classic skewed wavefront. Weight rows pass through a single
// register and are tagged with a wrapping row index. The block has no
// back-pressure: every read issued by the data mover is consumed.
//
// Ports
//   clk            : sole clock, rising edge
//   rst            : asynchronous active-high reset
//   mem0_ce0       : activation memory read enable (data arrives next cycle)
//   mem0_q0  [W]   : activation read data
//   mem1_ce0       : weight memory read enable (data arrives next cycle)
//   mem1_q0  [W]   : weight read data
//   act_o    [W]   : skewed activation lanes, lane i = [i*DATA_WIDTH +: DATA_WIDTH]
//   act_valid_o[PE_SIZE] : per-lane valid for act_o
//   weight_o [W]   : registered weight row
//   weight_valid_o : weight_o holds a new row this cycle
//   weight_row_o   : row index of weight_o
//   weight_load_o  : pulse alongside the last row of a weight block
//   act_done_o     : pulse when the activation pipeline has fully drained
//   busy_o         : some activation lane still holds valid data
module conv_skew_feeder #(
  parameter int PE_SIZE    = 16,
  parameter int DATA_WIDTH = 8,
  localparam int W     = PE_SIZE * DATA_WIDTH,
  localparam int ROW_W = (PE_SIZE > 1) ? $clog2(PE_SIZE) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem0_ce0,
  input  logic [W-1:0]       mem0_q0,
  input  logic               mem1_ce0,
  input  logic [W-1:0]       mem1_q0,
  output logic [W-1:0]       act_o,
  output logic [PE_SIZE-1:0] act_valid_o,
  output logic [W-1:0]       weight_o,
  output logic               weight_valid_o,
  output logic [ROW_W-1:0]   weight_row_o,
  output logic               weight_load_o,
  output logic               act_done_o,
  output logic               busy_o
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(PE_SIZE - 1);

  // Read-enable delay: aligns a valid flag with the memory's one-cycle latency.
  logic rd0_vld_q, rd0_vld_d;
  logic rd1_vld_q, rd1_vld_d;

  // Valid shift chain shared by all lanes. Stage j is the valid for the j-th
  // data register of every lane deep enough to have one; lane i exits at
  // stage i, so lane_vld_q[i] is exactly act_valid_o[i].
  logic [PE_SIZE-1:0] lane_vld_q, lane_vld_d;
  logic               act_done_q, act_done_d;

  logic [W-1:0]     weight_q, weight_d;
  logic             weight_valid_q, weight_valid_d;
  logic [ROW_W-1:0] weight_row_q, weight_row_d;
  logic             weight_load_q, weight_load_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;

  always_comb begin
    rd0_vld_d = mem0_ce0;
    rd1_vld_d = mem1_ce0;

    lane_vld_d    = '0;
    lane_vld_d[0] = rd0_vld_q;
    for (int i = 1; i < PE_SIZE; i++) begin
      lane_vld_d[i] = lane_vld_q[i-1];
    end

    // Drain is detected when the deepest lane is about to drop its last word
    // and nothing at all is following it. Any newer word anywhere in the
    // chain (including one entering stage 0) suppresses the pulse.
    act_done_d = lane_vld_q[PE_SIZE-1] && (lane_vld_d == '0);

    weight_d       = weight_q;
    weight_row_d   = weight_row_q;
    weight_valid_d = 1'b0;
    weight_load_d  = 1'b0;
    row_cnt_d      = row_cnt_q;
    if (rd1_vld_q) begin
      weight_d       = mem1_q0;
      weight_valid_d = 1'b1;
      weight_row_d   = row_cnt_q;
      weight_load_d  = (row_cnt_q == LAST_ROW);
      row_cnt_d      = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + ROW_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd0_vld_q      <= 1'b0;
      rd1_vld_q      <= 1'b0;
      lane_vld_q     <= '0;
      act_done_q     <= 1'b0;
      weight_q       <= '0;
      weight_valid_q <= 1'b0;
      weight_row_q   <= '0;
      weight_load_q  <= 1'b0;
      row_cnt_q      <= '0;
    end else begin
      rd0_vld_q      <= rd0_vld_d;
      rd1_vld_q      <= rd1_vld_d;
      lane_vld_q     <= lane_vld_d;
      act_done_q     <= act_done_d;
      weight_q       <= weight_d;
      weight_valid_q <= weight_valid_d;
      weight_row_q   <= weight_row_d;
      weight_load_q  <= weight_load_d;
      row_cnt_q      <= row_cnt_d;
    end
  end

  // Per-lane data delay lines. Lane gi owns gi+1 registers; each register
  // loads only when the matching valid stage loads a 1, so idle lanes hold
  // their last word instead of capturing whatever is on the memory bus.
  genvar gi;
  generate
    for (gi = 0; gi < PE_SIZE; gi++) begin : g_lane
      logic [gi:0][DATA_WIDTH-1:0] stage_q, stage_d;

      always_comb begin
        stage_d = stage_q;
        if (lane_vld_d[0]) begin
          stage_d[0] = mem0_q0[gi*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int j = 1; j <= gi; j++) begin
          if (lane_vld_d[j]) begin
            stage_d[j] = stage_q[j-1];
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage_q <= '0;
        end else begin
          stage_q <= stage_d;
        end
      end

      assign act_o[gi*DATA_WIDTH +: DATA_WIDTH] = stage_q[gi];
    end
  endgenerate

  assign act_valid_o    = lane_vld_q;
  assign busy_o         = |lane_vld_q;
  assign act_done_o     = act_done_q;
  assign weight_o       = weight_q;
  assign weight_valid_o = weight_valid_q;
  assign weight_row_o   = weight_row_q;
  assign weight_load_o  = weight_load_q;

endmodule
